// File: rtl/pulse_to_level_pkg.sv
// pulse_to_level_pkg: shared modes, FSM states and default pulse length for pulse_to_level
package pulse_to_level_pkg;
  typedef enum logic [1:0] {
    MODE_TOGGLE  = 2'b00,
    MODE_ONESHOT = 2'b01,
    MODE_RETRIG  = 2'b10,
    MODE_RSVD    = 2'b11
  } mode_e;
  typedef enum logic {
    ST_IDLE   = 1'b0,
    ST_ACTIVE = 1'b1
  } state_e;
  localparam int DEFAULT_LEN = 4;
endpackage

// File: rtl/pulse_len_counter.sv
// pulse_len_counter: loadable down-counter (load wins over dec, holds at zero); ports clk, rst, load, dec, load_val -> cnt, zero
module pulse_len_counter #(
  parameter int CNT_W = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             load,
  input  logic             dec,
  input  logic [CNT_W-1:0] load_val,
  output logic [CNT_W-1:0] cnt,
  output logic             zero
);
  assign zero = cnt == '0;
  always_ff @(posedge clk)
    if (rst) cnt <= '0;
    else if (load) cnt <= load_val;
    else if (dec && !zero) cnt <= cnt - 1'b1;
endmodule

// File: rtl/pulse_to_level.sv
// pulse_to_level: turns trigger pulses into toggle levels or timed pulses; ports clk, rst, trig, mode, len -> Q, busy, done
module pulse_to_level
  import pulse_to_level_pkg::*;
#(
  parameter int CNT_W       = 8,
  parameter int DEFAULT_LEN = pulse_to_level_pkg::DEFAULT_LEN
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             trig,
  input  logic [1:0]       mode,
  input  logic [CNT_W-1:0] len,
  output logic             Q,
  output logic             busy,
  output logic             done
);
  mode_e            m;
  state_e           st;
  logic             rtg;
  logic             tgl;
  logic [CNT_W-1:0] eff;
  logic             zero;
  logic             start;
  logic             reload;
  logic             dec;
  assign m      = mode_e'(mode);
  assign eff    = (len == '0) ? CNT_W'(DEFAULT_LEN) : len;
  assign start  = st == ST_IDLE && trig && m != MODE_TOGGLE;
  // rtg holds the mode captured when the pulse began, so mid-pulse mode changes are ignored
  assign reload = st == ST_ACTIVE && trig && rtg;
  assign dec    = st == ST_ACTIVE && !reload;
  pulse_len_counter #(.CNT_W(CNT_W)) u_cnt (
    .clk      (clk),
    .rst      (rst),
    .load     (start || reload),
    .dec      (dec),
    .load_val (eff - 1'b1),
    .cnt      (),
    .zero     (zero)
  );
  always_ff @(posedge clk)
    if (rst) begin
      st   <= ST_IDLE;
      rtg  <= 1'b0;
      tgl  <= 1'b0;
      Q    <= 1'b0;
      busy <= 1'b0;
      done <= 1'b0;
    end else begin
      done <= 1'b0;
      if (st == ST_IDLE) begin
        if (start) begin
          st   <= ST_ACTIVE;
          rtg  <= m == MODE_RETRIG;
          tgl  <= 1'b0;
          Q    <= 1'b1;
          busy <= 1'b1;
        end else if (trig) begin
          tgl <= ~tgl;
          Q   <= ~tgl;
        end
      end else if (!reload && zero) begin
        st   <= ST_IDLE;
        Q    <= 1'b0;
        busy <= 1'b0;
        done <= 1'b1;
      end
    end
endmodule

// File: tb/tb_pulse_to_level.sv
// tb_pulse_to_level: scoreboard bench with a remaining-cycles reference model for pulse_to_level
module tb_pulse_to_level;
  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       trig = 1'b0;
  logic [1:0] mode = 2'b00;
  logic [7:0] len = 8'd0;
  logic       Q, busy, done;
  int         errors = 0;
  int         checks = 0;
  int         cyc = 0;
  logic [2:0] exp_q[$];
  int         rem = 0;
  bit         tgl = 0;
  bit         rtg = 0;
  always #5 clk = ~clk;
  pulse_to_level dut (
    .clk  (clk),
    .rst  (rst),
    .trig (trig),
    .mode (mode),
    .len  (len),
    .Q    (Q),
    .busy (busy),
    .done (done)
  );
  // rem = high cycles still owed after this edge, counting the current one
  task automatic step(input bit t, input bit [1:0] md, input bit [7:0] ln, input bit r);
    int  eff;
    bit  d;
    @(negedge clk);
    trig = t;
    mode = md;
    len  = ln;
    rst  = r;
    eff  = (ln == 0) ? 4 : ln;
    d    = 0;
    if (r) begin
      rem = 0;
      tgl = 0;
      rtg = 0;
    end else if (rem > 0) begin
      if (t && rtg) rem = eff;
      else begin
        rem = rem - 1;
        d = rem == 0;
      end
    end else if (t) begin
      if (md == 2'b00) tgl = !tgl;
      else begin
        tgl = 0;
        rtg = md == 2'b10;
        rem = eff;
      end
    end
    exp_q.push_back({(rem > 0) || tgl, rem > 0, d});
  endtask
  task automatic idle(input int n, input bit [1:0] md, input bit [7:0] ln);
    for (int i = 0; i < n; i++) step(0, md, ln, 0);
  endtask
  initial begin
    logic [2:0] e;
    forever begin
      @(posedge clk);
      #1;
      cyc++;
      if (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        checks++;
        if ({Q, busy, done} !== e) begin
          errors++;
          $display("FAIL outputs cycle %0d: Q/busy/done got %b%b%b expected %b", cyc, Q, busy, done, e);
        end
      end
    end
  end
  initial begin
    step(0, 0, 0, 1);
    step(0, 0, 0, 1);
    idle(2, 0, 0);
    step(1, 0, 0, 0);
    idle(4, 0, 0);
    step(1, 0, 0, 0);
    idle(3, 0, 0);
    step(1, 0, 0, 0);
    idle(2, 0, 0);
    step(1, 0, 0, 0);
    idle(3, 1, 5);
    step(1, 1, 5, 0);
    idle(1, 1, 5);
    step(1, 1, 5, 0);
    step(1, 1, 5, 0);
    idle(5, 1, 5);
    step(1, 2, 3, 0);
    idle(1, 2, 3);
    step(1, 2, 3, 0);
    idle(5, 2, 3);
    step(1, 1, 0, 0);
    idle(6, 1, 0);
    step(1, 1, 1, 0);
    idle(3, 1, 1);
    step(1, 2, 3, 0);
    idle(2, 2, 3);
    step(1, 2, 3, 0);
    idle(5, 2, 3);
    step(1, 1, 10, 0);
    idle(3, 1, 10);
    step(0, 1, 10, 1);
    idle(2, 1, 10);
    step(1, 1, 10, 0);
    idle(12, 1, 10);
    step(1, 0, 0, 0);
    step(1, 1, 2, 0);
    idle(4, 1, 2);
    step(1, 1, 2, 0);
    step(1, 1, 2, 0);
    step(1, 1, 2, 0);
    idle(3, 0, 0);
    step(1, 1, 255, 0);
    idle(258, 1, 255);
    for (int i = 0; i < 3000; i++)
      step($urandom_range(3) == 0, 2'($urandom_range(3)),
           ($urandom_range(15) == 0) ? 8'($urandom_range(255)) : 8'($urandom_range(7)),
           $urandom_range(199) == 0);
    repeat (2) @(posedge clk);
    #2;
    checks++;
    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL drain: %0d expected entries left, required 0", exp_q.size());
    end
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
